// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its decoder.
package instr_sequencer_pkg;

    // Instruction word layout
    localparam int unsigned INSTR_W     = 9;
    localparam int unsigned TYPE_BIT    = 8;
    localparam int unsigned ROP_LSB     = 4;
    localparam int unsigned ROP_W       = 4;
    localparam int unsigned REG_LSB     = 0;
    localparam int unsigned REG_W       = 4;
    localparam int unsigned IOP_LSB     = 5;
    localparam int unsigned IOP_W       = 3;
    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned IMM_FIELD_W = 5;
    localparam int unsigned IMM_W       = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMWAIT   = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    // R-type opcodes
    localparam logic [ROP_W-1:0] R_ADD     = 4'd0;
    localparam logic [ROP_W-1:0] R_LOAD    = 4'd1;
    localparam logic [ROP_W-1:0] R_OP2     = 4'd2;
    localparam logic [ROP_W-1:0] R_MVTO    = 4'd3;
    localparam logic [ROP_W-1:0] R_OP4     = 4'd4;
    localparam logic [ROP_W-1:0] R_OP5     = 4'd5;
    localparam logic [ROP_W-1:0] R_OP6     = 4'd6;
    localparam logic [ROP_W-1:0] R_OP7     = 4'd7;
    localparam logic [ROP_W-1:0] R_STR     = 4'd8;
    localparam logic [ROP_W-1:0] R_OP9     = 4'd9;
    localparam logic [ROP_W-1:0] R_OP10    = 4'd10;
    localparam logic [ROP_W-1:0] R_BTRU    = 4'd11;
    localparam logic [ROP_W-1:0] R_OP12    = 4'd12;
    localparam logic [ROP_W-1:0] R_OP13    = 4'd13;
    localparam logic [ROP_W-1:0] R_UNDEF14 = 4'd14;
    localparam logic [ROP_W-1:0] R_HALT    = 4'd15;

    // I-type opcodes
    localparam logic [IOP_W-1:0] I_OP0    = 3'd0;
    localparam logic [IOP_W-1:0] I_ADDI   = 3'd1;
    localparam logic [IOP_W-1:0] I_OP2    = 3'd2;
    localparam logic [IOP_W-1:0] I_JMP    = 3'd3;
    localparam logic [IOP_W-1:0] I_OP4    = 3'd4;
    localparam logic [IOP_W-1:0] I_OP5    = 3'd5;
    localparam logic [IOP_W-1:0] I_UNDEF6 = 3'd6;
    localparam logic [IOP_W-1:0] I_UNDEF7 = 3'd7;

endpackage

// File: rtl/instr_decode.sv
// Opcode classifier: maps the latched opcode to write, memory and control-flow classes.
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic             r_type,
    input  logic [ROP_W-1:0] r_op,
    input  logic [IOP_W-1:0] i_op,
    output logic             acc_wr_c,
    output logic             reg_wr_c,
    output logic             mem_rd_c,
    output logic             mem_wr_c,
    output logic             halt_c,
    output logic             jump_c,
    output logic             cond_br_c
);

    // Class flags; undefined opcodes fall through with every flag low
    always_comb begin
        acc_wr_c  = 1'b0;
        reg_wr_c  = 1'b0;
        mem_rd_c  = 1'b0;
        mem_wr_c  = 1'b0;
        halt_c    = 1'b0;
        jump_c    = 1'b0;
        cond_br_c = 1'b0;
        if (r_type) begin
            case (r_op)
                R_ADD, R_OP2, R_OP4, R_OP5, R_OP6, R_OP7,
                R_OP9, R_OP10, R_OP12, R_OP13: acc_wr_c = 1'b1;
                R_LOAD: begin
                    acc_wr_c = 1'b1;
                    mem_rd_c = 1'b1;
                end
                R_MVTO:    reg_wr_c  = 1'b1;
                R_STR:     mem_wr_c  = 1'b1;
                R_BTRU:    cond_br_c = 1'b1;
                R_UNDEF14: ;
                R_HALT:    halt_c    = 1'b1;
                default: ;
            endcase
        end else begin
            case (i_op)
                I_OP0, I_ADDI, I_OP2, I_OP4, I_OP5: acc_wr_c = 1'b1;
                I_JMP:              jump_c = 1'b1;
                I_UNDEF6, I_UNDEF7: ;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memwait/writeback control with PC.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned PCW = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               BranchIn,
    input  logic [PCW-1:0]     TargetIn,
    input  logic               MemAck,
    output logic [PCW-1:0]     PC,
    output logic               Type,
    output logic [ROP_W-1:0]   RTypeOP,
    output logic [IOP_W-1:0]   ITypeOP,
    output logic [REG_W-1:0]   RegAddr,
    output logic [IMM_W-1:0]   Immediate,
    output logic               AccWrEn,
    output logic               RegWrEn,
    output logic               MemRdReq,
    output logic               MemWrReq,
    output logic               Busy,
    output logic               Done
);

    state_e             state_q, state_d;
    logic [PCW-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               br_taken_q, br_taken_d;
    logic               acc_wr_en_q, acc_wr_en_d;
    logic               reg_wr_en_q, reg_wr_en_d;
    logic               mem_rd_req_q, mem_rd_req_d;
    logic               mem_wr_req_q, mem_wr_req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic acc_wr_c, reg_wr_c, mem_rd_c, mem_wr_c, halt_c, jump_c, cond_br_c;

    instr_decode u_decode (
        .r_type    (ir_q[TYPE_BIT]),
        .r_op      (ir_q[ROP_LSB +: ROP_W]),
        .i_op      (ir_q[IOP_LSB +: IOP_W]),
        .acc_wr_c  (acc_wr_c),
        .reg_wr_c  (reg_wr_c),
        .mem_rd_c  (mem_rd_c),
        .mem_wr_c  (mem_wr_c),
        .halt_c    (halt_c),
        .jump_c    (jump_c),
        .cond_br_c (cond_br_c)
    );

    // Next state, PC, instruction latch and next-cycle strobes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        br_taken_d = br_taken_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = InstrIn;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = halt_c ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                br_taken_d = cond_br_c & BranchIn;
                state_d    = (mem_rd_c | mem_wr_c) ? S_MEMWAIT : S_WRITEBACK;
            end
            S_MEMWAIT: begin
                if (MemAck) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
                if (jump_c || br_taken_q) begin
                    pc_d = TargetIn;
                end else begin
                    pc_d = pc_q + PCW'(1);
                end
            end
            S_HALT: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered, so they are derived from the state being entered
        acc_wr_en_d  = (state_d == S_WRITEBACK) && acc_wr_c;
        reg_wr_en_d  = (state_d == S_WRITEBACK) && reg_wr_c;
        mem_rd_req_d = (state_d == S_MEMWAIT) && mem_rd_c;
        mem_wr_req_d = (state_d == S_MEMWAIT) && mem_wr_c;
        busy_d       = (state_d != S_IDLE) && (state_d != S_HALT);
        done_d       = (state_d == S_HALT);
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            br_taken_q   <= 1'b0;
            acc_wr_en_q  <= 1'b0;
            reg_wr_en_q  <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            br_taken_q   <= br_taken_d;
            acc_wr_en_q  <= acc_wr_en_d;
            reg_wr_en_q  <= reg_wr_en_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign PC        = pc_q;
    assign Type      = ir_q[TYPE_BIT];
    assign RTypeOP   = ir_q[ROP_LSB +: ROP_W];
    assign ITypeOP   = ir_q[IOP_LSB +: IOP_W];
    assign RegAddr   = ir_q[REG_LSB +: REG_W];
    assign Immediate = IMM_W'(ir_q[IMM_LSB +: IMM_FIELD_W]);
    assign AccWrEn   = acc_wr_en_q;
    assign RegWrEn   = reg_wr_en_q;
    assign MemRdReq  = mem_rd_req_q;
    assign MemWrReq  = mem_wr_req_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer.
module tb_instr_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [8:0] InstrIn;
    logic       BranchIn;
    logic [9:0] TargetIn;
    logic       MemAck;
    logic [9:0] PC;
    logic       Type;
    logic [3:0] RTypeOP;
    logic [2:0] ITypeOP;
    logic [3:0] RegAddr;
    logic [7:0] Immediate;
    logic       AccWrEn, RegWrEn, MemRdReq, MemWrReq, Busy, Done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_pc;

    typedef struct packed {
        logic acc;
        logic rw;
        logic rd;
        logic wr;
    } exp_t;
    exp_t sb_q[$];

    always #5 Clk = ~Clk;

    instr_sequencer #(.PCW(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstrIn(InstrIn),
        .BranchIn(BranchIn), .TargetIn(TargetIn), .MemAck(MemAck),
        .PC(PC), .Type(Type), .RTypeOP(RTypeOP), .ITypeOP(ITypeOP),
        .RegAddr(RegAddr), .Immediate(Immediate), .AccWrEn(AccWrEn),
        .RegWrEn(RegWrEn), .MemRdReq(MemRdReq), .MemWrReq(MemWrReq),
        .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Runs one instruction starting in its FETCH cycle; ends in the next FETCH cycle.
    task automatic run_instr(input string name, input logic [8:0] instr, input logic br,
                             input logic [9:0] tgt, input int n_mem,
                             input logic e_acc, input logic e_rw, input logic e_rd,
                             input logic e_wr, input logic [9:0] e_pc);
        int   lat;
        logic is_mem;
        exp_t e;
        is_mem   = e_rd | e_wr;
        lat      = is_mem ? 4 + n_mem : 4;
        InstrIn  = instr;
        BranchIn = br;
        TargetIn = tgt;
        for (int c = 1; c <= lat; c++) begin
            e.acc = e_acc && (c == lat);
            e.rw  = e_rw  && (c == lat);
            e.rd  = e_rd  && (c >= 4) && (c < lat);
            e.wr  = e_wr  && (c >= 4) && (c < lat);
            sb_q.push_back(e);
        end
        for (int c = 1; c <= lat; c++) begin
            e = sb_q.pop_front();
            chk({name, "/AccWrEn"},  AccWrEn,  e.acc);
            chk({name, "/RegWrEn"},  RegWrEn,  e.rw);
            chk({name, "/MemRdReq"}, MemRdReq, e.rd);
            chk({name, "/MemWrReq"}, MemWrReq, e.wr);
            chk({name, "/Busy"},     Busy,     1);
            chk({name, "/Done"},     Done,     0);
            chk({name, "/PC_hold"},  PC,       exp_pc);
            if (c >= 2) begin
                chk({name, "/Type"}, Type, instr[8]);
                if (instr[8]) begin
                    chk({name, "/RTypeOP"}, RTypeOP, instr[7:4]);
                    chk({name, "/RegAddr"}, RegAddr, instr[3:0]);
                end else begin
                    chk({name, "/ITypeOP"},   ITypeOP,   instr[7:5]);
                    chk({name, "/Immediate"}, Immediate, {3'b000, instr[4:0]});
                end
            end
            // MemAck outside MEMWAIT is driven high on purpose; it must be ignored
            MemAck = is_mem ? ((c <= 3) || (c == 3 + n_mem)) : 1'b1;
            cyc();
        end
        MemAck = 1'b0;
        chk({name, "/PC_next"}, PC, e_pc);
        exp_pc = e_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; InstrIn = '0; BranchIn = 1'b0;
        TargetIn = '0; MemAck = 1'b0;
        cyc();
        cyc();
        chk("rst/PC", PC, 0);
        chk("rst/Busy", Busy, 0);
        chk("rst/Done", Done, 0);
        chk("rst/strobes", {AccWrEn, RegWrEn, MemRdReq, MemWrReq}, 0);
        chk("rst/ir", {Type, RTypeOP, RegAddr}, 0);
        Reset = 1'b0;
        cyc();
        chk("idle/Busy", Busy, 0);

        // Start from idle
        Start = 1'b1;
        cyc();
        Start  = 1'b0;
        exp_pc = 10'h000;
        run_instr("addi", 9'h025, 1'b0, 10'h3C0, 0, 1, 0, 0, 0, 10'h001);
        run_instr("load", 9'h112, 1'b0, 10'h3C0, 3, 1, 0, 1, 0, 10'h002);
        run_instr("btru1", 9'h1B0, 1'b1, 10'h02A, 0, 0, 0, 0, 0, 10'h02A);
        run_instr("btru0", 9'h1B0, 1'b0, 10'h0F0, 0, 0, 0, 0, 0, 10'h02B);
        run_instr("mvto", 9'h135, 1'b1, 10'h0F0, 0, 0, 1, 0, 0, 10'h02C);
        run_instr("str", 9'h184, 1'b0, 10'h0F0, 1, 0, 0, 0, 1, 10'h02D);
        run_instr("i6", 9'h0C3, 1'b1, 10'h0F0, 0, 0, 0, 0, 0, 10'h02E);
        run_instr("r14", 9'h1E0, 1'b1, 10'h0F0, 0, 0, 0, 0, 0, 10'h02F);

        // Reset while a store request is pending in MEMWAIT
        InstrIn = 9'h184;
        cyc();
        cyc();
        cyc();
        chk("strrst/req1", MemWrReq, 1);
        cyc();
        chk("strrst/req2", MemWrReq, 1);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        chk("strrst/MemWrReq", MemWrReq, 0);
        chk("strrst/Busy", Busy, 0);
        chk("strrst/Done", Done, 0);
        chk("strrst/PC", PC, 0);
        chk("strrst/ir", {Type, RTypeOP}, 0);
        MemAck = 1'b1;
        cyc();
        cyc();
        chk("lateack/Busy", Busy, 0);
        chk("lateack/strobes", {AccWrEn, RegWrEn, MemRdReq, MemWrReq}, 0);
        MemAck = 1'b0;
        Start  = 1'b1;
        cyc();
        Start  = 1'b0;
        exp_pc = 10'h000;
        run_instr("addi2", 9'h025, 1'b0, 10'h155, 0, 1, 0, 0, 0, 10'h001);

        // HALT then restart
        InstrIn = 9'h1F0;
        cyc();
        chk("halt/dec_Busy", Busy, 1);
        cyc();
        chk("halt/Done", Done, 1);
        chk("halt/Busy", Busy, 0);
        chk("halt/strobes", {AccWrEn, RegWrEn, MemRdReq, MemWrReq}, 0);
        chk("halt/PC", PC, 10'h001);
        cyc();
        chk("halt/Done_hold", Done, 1);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk("restart/PC", PC, 0);
        chk("restart/Busy", Busy, 1);
        chk("restart/Done", Done, 0);
        exp_pc = 10'h000;

        // Jump to top of PC space, then ADD wraps PC; Start held while busy
        run_instr("jmp", 9'h060, 1'b0, 10'h3FF, 0, 0, 0, 0, 0, 10'h3FF);
        Start = 1'b1;
        run_instr("add_wrap", 9'h101, 1'b0, 10'h155, 0, 1, 0, 0, 0, 10'h000);
        Start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
